// File: rtl/gb_timer_irq.sv
// Divider/timer (DIV, TIMA, TMA, TAC) and interrupt flag/enable (IF, IE) registers
// for the gb_cpu bus; reads are combinational, writes land on the rising edge.
module gb_timer_irq (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr_i,
  input  logic [7:0]  data_i,
  input  logic        wr_en_i,
  input  logic [4:0]  irq_req_i,
  input  logic [4:0]  irq_ack_i,
  output logic [7:0]  data_o,
  output logic        hit_o,
  output logic [4:0]  irq_pending_o
);

  typedef enum logic {ST_RUN = 1'b0, ST_RELOAD = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [13:0] r_div_cnt;
  logic [7:0]  r_tima;
  logic [7:0]  r_tma;
  logic [2:0]  r_tac;
  logic [4:0]  r_if;
  logic [7:0]  r_ie;
  logic        r_tick;

  logic        w_sel_div, w_sel_tima, w_sel_tma, w_sel_tac, w_sel_if, w_sel_ie;
  logic        w_wr_div, w_wr_tima, w_wr_tma, w_wr_tac, w_wr_if, w_wr_ie;
  logic        w_tick_bit, w_tick, w_tick_fall, w_timer_set;
  logic [7:0]  w_tima_next, w_tma_next;
  logic [4:0]  w_set_vec, w_if_next;

  assign w_sel_div  = (addr_i == 16'hFF04);
  assign w_sel_tima = (addr_i == 16'hFF05);
  assign w_sel_tma  = (addr_i == 16'hFF06);
  assign w_sel_tac  = (addr_i == 16'hFF07);
  assign w_sel_if   = (addr_i == 16'hFF0F);
  assign w_sel_ie   = (addr_i == 16'hFFFF);
  assign hit_o      = w_sel_div | w_sel_tima | w_sel_tma | w_sel_tac | w_sel_if | w_sel_ie;

  assign w_wr_div  = wr_en_i & w_sel_div;
  assign w_wr_tima = wr_en_i & w_sel_tima;
  assign w_wr_tma  = wr_en_i & w_sel_tma;
  assign w_wr_tac  = wr_en_i & w_sel_tac;
  assign w_wr_if   = wr_en_i & w_sel_if;
  assign w_wr_ie   = wr_en_i & w_sel_ie;

  // Divider tap selected by TAC[1:0]
  always_comb begin
    w_tick_bit = 1'b0;
    case (r_tac[1:0])
      2'b00:   w_tick_bit = r_div_cnt[7];
      2'b01:   w_tick_bit = r_div_cnt[1];
      2'b10:   w_tick_bit = r_div_cnt[3];
      2'b11:   w_tick_bit = r_div_cnt[5];
      default: w_tick_bit = 1'b0;
    endcase
  end

  // Falling edge of the gated tap drives TIMA, so DIV/TAC writes can glitch it on purpose.
  assign w_tick      = r_tac[2] & w_tick_bit;
  assign w_tick_fall = r_tick & ~w_tick;
  assign w_tma_next  = w_wr_tma ? data_i : r_tma;

  // TIMA next value and overflow/reload sequencing
  always_comb begin
    w_state_next = r_state;
    w_tima_next  = r_tima;
    w_timer_set  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_wr_tima) begin
          w_tima_next = data_i;
        end else if (w_tick_fall) begin
          if (r_tima == 8'hFF) begin
            w_tima_next  = 8'h00;
            w_state_next = ST_RELOAD;
          end else begin
            w_tima_next = r_tima + 8'd1;
          end
        end else begin
          w_tima_next = r_tima;
        end
      end
      ST_RELOAD: begin
        w_state_next = ST_RUN;
        if (w_wr_tima) begin
          w_tima_next = data_i;
        end else begin
          w_tima_next = w_tma_next;
          w_timer_set = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_RUN;
        w_tima_next  = r_tima;
      end
    endcase
  end

  assign w_set_vec     = {irq_req_i[4:3], w_timer_set, irq_req_i[1:0]};
  assign w_if_next     = ((w_wr_if ? data_i[4:0] : r_if) & ~irq_ack_i) | w_set_vec;
  assign irq_pending_o = r_ie[4:0] & r_if;

  // Register read mux
  always_comb begin
    data_o = 8'hFF;
    case (addr_i)
      16'hFF04: data_o = r_div_cnt[13:6];
      16'hFF05: data_o = r_tima;
      16'hFF06: data_o = r_tma;
      16'hFF07: data_o = {5'b11111, r_tac};
      16'hFF0F: data_o = {3'b111, r_if};
      16'hFFFF: data_o = r_ie;
      default:  data_o = 8'hFF;
    endcase
  end

  // Overflow FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_next;
  end

  // Divider, timer and interrupt register state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt <= 14'd0;
      r_tick    <= 1'b0;
      r_tima    <= 8'h00;
      r_tma     <= 8'h00;
      r_tac     <= 3'b000;
      r_if      <= 5'b00000;
      r_ie      <= 8'h00;
    end else begin
      r_div_cnt <= w_wr_div ? 14'd0 : r_div_cnt + 14'd1;
      r_tick    <= w_tick;
      r_tima    <= w_tima_next;
      r_tma     <= w_tma_next;
      r_tac     <= w_wr_tac ? data_i[2:0] : r_tac;
      r_if      <= w_if_next;
      r_ie      <= w_wr_ie ? data_i : r_ie;
    end
  end

endmodule
